// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus IF/ID boundary.
// Holds the fetch entry bundle and the canonical NOP encoding.
package kamus_pkg;

    localparam logic [31:0] KAMUS_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } if_id_entry_t;

endpackage

// File: rtl/kamus_if_id_buf.sv
// Registered IF-to-ID entry FIFO with flush and an empty-NOP head.
// Optional KAMUS_IFID_FULL_PUSH_EN lets a full buffer accept a push during a pop.
module kamus_if_id_buf
    import kamus_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = KAMUS_NOP
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    output logic                       if_ready_o,
    input  logic [31:0]                if_instr_i,
    input  logic [31:0]                if_pc_i,
    input  logic [31:0]                if_next_pc_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [31:0]                id_instr_o,
    output logic [31:0]                id_pc_o,
    output logic [31:0]                id_next_pc_o,
    output logic                       id_illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if_id_entry_t  mem [DEPTH];
    if_id_entry_t  head;
    if_id_entry_t  wr_entry;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

`ifdef KAMUS_IFID_FULL_PUSH_EN
    assign if_ready_o = !full || id_ready_i;
`else
    assign if_ready_o = !full;
`endif

    // Flush wins over both handshakes.
    assign push = if_valid_i && if_ready_o && !flush_i;
    assign pop  = !empty && id_ready_i && !flush_i;

    assign wr_entry.instr   = if_instr_i;
    assign wr_entry.pc      = if_pc_i;
    assign wr_entry.next_pc = if_next_pc_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head = mem[rd_ptr];

    assign id_valid_o   = !empty;
    assign id_instr_o   = empty ? NOP_INSTR : head.instr;
    assign id_pc_o      = empty ? 32'h0 : head.pc;
    assign id_next_pc_o = empty ? 32'h0 : head.next_pc;
    assign id_illegal_o = !empty && (head.instr[1:0] != 2'b11);
    assign occupancy_o  = count;

endmodule

// File: doc/kamus_if_id_buf.md
KAMUS_IF_ID_BUF -- requirements
Module: kamus_if_id_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffered fetch entries (power of two, at least 2).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction driven to ID when no entry is valid.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all buffered entries.
REQ-006 SHALL have port if_valid_i, input, 1 bit: the IF entry is valid.
REQ-007 SHALL have port if_ready_o, output, 1 bit: the buffer accepts an entry this cycle.
REQ-008 SHALL have port if_instr_i, input, 32 bits: the fetched instruction word.
REQ-009 SHALL have port if_pc_i, input, 32 bits: the instruction address.
REQ-010 SHALL have port if_next_pc_i, input, 32 bits: pc+4.
REQ-011 SHALL have port id_valid_o, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port id_ready_i, input, 1 bit: ID consumes the head entry.
REQ-013 SHALL have ports id_instr_o, id_pc_o and id_next_pc_o, output, 32 bits each: the head entry fields.
REQ-014 SHALL have port id_illegal_o, output, 1 bit: the head entry has instr[1:0] != 2'b11.
REQ-015 SHALL have port occupancy_o, output, $clog2(DEPTH+1) bits: the current entry count.

Function
REQ-016 SHALL push an entry when if_valid_i && if_ready_o, and pop the head when id_valid_o && id_ready_i.
REQ-017 SHALL hold an entry pushed in cycle N at the head (if the buffer was empty) with id_valid_o=1 in cycle N+1, giving one cycle of latency and no combinational input-to-output path.
REQ-018 SHALL drive if_ready_o = (occupancy_o < DEPTH) in the baseline build.
REQ-019 SHALL, when empty, drive id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o and id_next_pc_o = 0, and id_illegal_o=0.
REQ-020 SHALL gate id_illegal_o by id_valid_o.
REQ-021 SHALL, on a simultaneous push and pop, leave the occupancy unchanged and preserve FIFO order.
REQ-022 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH with no bubble at the wrap point.
REQ-023 SHALL have flush_i take priority over push and pop: the next cycle has occupancy 0, both pointers at 0 and id_valid_o=0, and any entry offered in the flush cycle is dropped.
REQ-024 SHALL NOT let a pop on an empty buffer or a push on a full buffer change any state.

Reset
REQ-025 SHALL, while rst_ni=0, asynchronously force occupancy and pointers to 0, id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o and id_next_pc_o = 0, id_illegal_o=0 and if_ready_o=1.
REQ-026 SHALL discard, on a reset asserted mid-operation, all entries, with no partial entry surviving deassertion.
REQ-027 SHALL NOT reset the storage array data; only valid state is reset.

Configuration
REQ-028 SHALL, when KAMUS_IFID_FULL_PUSH_EN is defined, drive if_ready_o = (occupancy_o < DEPTH) || id_ready_i, allowing a push into a full buffer in the same cycle as a pop.
REQ-029 SHALL, when KAMUS_IFID_FULL_PUSH_EN is undefined, have no id_ready_i-to-if_ready_o path, so a full buffer always refuses a push.
REQ-030 SHALL still have flush_i take precedence with KAMUS_IFID_FULL_PUSH_EN defined.

Structure
REQ-031 SHALL take from kamus_pkg the struct typedef if_id_entry_t {instr, pc, next_pc}, which kamus_pkg SHALL define.
REQ-032 SHALL take from kamus_pkg the constant KAMUS_NOP = 32'h0000_0013, which kamus_pkg SHALL define as the NOP_INSTR default.
REQ-033 SHALL be a single module with no sub-module, the storage being an array of if_id_entry_t.

Verification
REQ-034 SHALL cover: reset, then push {instr 32'h0010_0093, pc 0, next_pc 4} -> next cycle id_valid_o=1, id_instr_o=32'h0010_0093 and occupancy 1.
REQ-035 SHALL cover: id_ready_i=0 with 3 pushes at DEPTH=2 -> if_ready_o=0 after 2, the 3rd entry not stored and occupancy 2.
REQ-036 SHALL cover: full buffer with simultaneous push and pop -> baseline refuses the push; with KAMUS_IFID_FULL_PUSH_EN, occupancy stays 2 and order is preserved.
REQ-037 SHALL cover: flush_i with occupancy 2 plus an offered push -> next cycle occupancy 0, id_valid_o=0 and id_instr_o=32'h0000_0013.
REQ-038 SHALL cover: 10 consecutive entries streamed with id_ready_i=1 -> output pcs are 0,4,...,36 in order with no gaps across pointer wrap.
REQ-039 SHALL cover: head instr 32'h0000_4501 -> id_illegal_o=1; rst_ni pulsed low mid-stream -> all outputs at reset values immediately, before the next clock edge.
